// File: rtl/scrypt_smix_io.sv
// rtl/scrypt_smix_io.sv - word-serial load/unload buffer around the SMIX core.
// Optional byte swap on both ports when SCRYPT_IO_BSWAP_EN is defined.
module scrypt_smix_io #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 32
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_word,
  output logic                     in_ready,
  output logic [WORD_W*NWORDS-1:0] smix_data,
  output logic                     smix_enable,
  input  logic [WORD_W*NWORDS-1:0] smix_hash,
  input  logic                     smix_done,
  output logic                     out_valid,
  output logic [WORD_W-1:0]        out_word,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_UNLOAD} state_t;

  state_t                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           idx_d;
  logic [WORD_W*NWORDS-1:0]   buf_q;
  logic [WORD_W-1:0]          out_word_q;
  logic                       in_ready_q;
  logic                       smix_enable_q;
  logic                       out_valid_q;
  logic                       busy_q;
  logic [WORD_W-1:0]          in_word_sw;

`ifdef SCRYPT_IO_BSWAP_EN
  function automatic logic [WORD_W-1:0] bswap(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int b = 0; b < WORD_W / 8; b++) begin
      r[b*8 +: 8] = w[WORD_W-8-b*8 +: 8];
    end
    return r;
  endfunction

  assign in_word_sw = bswap(in_word);
  assign out_word   = bswap(out_word_q);
`else
  assign in_word_sw = in_word;
  assign out_word   = out_word_q;
`endif

  assign idx_d       = idx_q + 1'b1;
  assign smix_data   = buf_q;
  assign in_ready    = in_ready_q;
  assign smix_enable = smix_enable_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_LOAD;
      idx_q         <= '0;
      buf_q         <= '0;
      out_word_q    <= '0;
      in_ready_q    <= 1'b1;
      smix_enable_q <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      smix_enable_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (in_valid && in_ready_q) begin
            buf_q[idx_q*WORD_W +: WORD_W] <= in_word_sw;
            idx_q <= idx_d;
            if (idx_q == IDX_LAST) begin
              state_q       <= S_START;
              in_ready_q    <= 1'b0;
              busy_q        <= 1'b1;
              smix_enable_q <= 1'b1;
            end
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          // Word 0 is preloaded so out_word is valid in the first UNLOAD cycle.
          if (smix_done) begin
            buf_q       <= smix_hash;
            out_word_q  <= smix_hash[WORD_W-1:0];
            out_valid_q <= 1'b1;
            state_q     <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            idx_q <= idx_d;
            if (idx_q == IDX_LAST) begin
              state_q     <= S_LOAD;
              out_valid_q <= 1'b0;
              out_word_q  <= '0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              out_word_q <= buf_q[idx_d*WORD_W +: WORD_W];
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_scrypt_smix_io.sv
// tb/tb_scrypt_smix_io.sv - directed table-driven bench for scrypt_smix_io.
module tb_scrypt_smix_io;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          in_valid;
  logic [31:0]   in_word;
  logic          in_ready;
  logic [1023:0] smix_data;
  logic          smix_enable;
  logic [1023:0] smix_hash;
  logic          smix_done;
  logic          out_valid;
  logic [31:0]   out_word;
  logic          out_ready;
  logic          busy;

  scrypt_smix_io dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .smix_data(smix_data), .smix_enable(smix_enable),
    .smix_hash(smix_hash), .smix_done(smix_done),
    .out_valid(out_valid), .out_word(out_word), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] in_w;
    logic [31:0] exp_data;
    logic [31:0] hash_w;
    logic [31:0] exp_out;
  } vec_t;

  vec_t          vecs [32];
  logic [31:0]   blk [32];
  logic [31:0]   hw [32];
  logic [31:0]   exp_w [32];
  logic [1023:0] hash_v;
  int            n_checks = 0;
  int            n_pass = 0;
  int            en_count = 0;
  int            en0;

  always @(negedge clk) if (smix_enable) en_count++;

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef SCRYPT_IO_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Entered just after a negedge; returns at the negedge following the last transfer.
  task automatic load_block(input int cnt);
    int k = 0;
    int guard = 0;
    logic acc;
    while (k < cnt && guard < 200) begin
      in_valid = 1'b1;
      in_word  = blk[k];
      acc = in_ready;
      @(negedge clk);
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    if (k < cnt) chk("load_timeout", k, cnt);
  endtask

  task automatic run_smix();
    for (int k = 0; k < 32; k++) hash_v[k*32 +: 32] = hw[k];
    @(negedge clk);
    chk("wait_enable_low", smix_enable, 1'b0);
    chk("wait_busy", busy, 1'b1);
    chk("wait_in_ready", in_ready, 1'b0);
    repeat (8) @(negedge clk);
    chk("pre_done_out_valid", out_valid, 1'b0);
    smix_hash = hash_v;
    smix_done = 1'b1;
    @(negedge clk);
    smix_done = 1'b0;
    smix_hash = ~hash_v;
    chk("done_to_out_valid", out_valid, 1'b1);
  endtask

  task automatic unload(input bit toggle, input bit stray);
    int n = 0;
    int c = 0;
    bit held = 1'b0;
    logic [31:0] held_w = '0;
    while (n < 32 && c < 200) begin
      out_ready = toggle ? ((c % 2) == 0) : 1'b1;
      if (stray) begin
        in_valid  = 1'b1;
        in_word   = 32'hBAD0_0000 | 32'(c);
        smix_done = (c == 3);
      end
      if (held) chk("hold_stable", out_word, held_w);
      chk("unload_valid", out_valid, 1'b1);
      if (stray) chk("stray_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        chk($sformatf("out_word[%0d]", n), out_word, exp_w[n]);
        n++;
        held = 1'b0;
        if (n == 32) begin
          in_valid  = 1'b0;
          smix_done = 1'b0;
        end
      end else begin
        held   = 1'b1;
        held_w = out_word;
      end
      @(negedge clk);
      c++;
    end
    in_valid  = 1'b0;
    smix_done = 1'b0;
    out_ready = 1'b0;
    if (n < 32) chk("unload_timeout", n, 32);
    chk("post_unload_in_ready", in_ready, 1'b1);
    chk("post_unload_out_valid", out_valid, 1'b0);
    chk("post_unload_busy", busy, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; in_word = '0;
    smix_hash = '0; smix_done = 1'b0; out_ready = 1'b0;

    for (int k = 0; k < 32; k++) begin
      vecs[k].in_w   = 32'(k);
      vecs[k].hash_w = 32'hC0DE_0000 | 32'(k);
`ifdef SCRYPT_IO_BSWAP_EN
      vecs[k].exp_data = {8'(k), 24'h0};
      vecs[k].exp_out  = {8'(k), 8'h00, 8'hDE, 8'hC0};
`else
      vecs[k].exp_data = 32'(k);
      vecs[k].exp_out  = 32'hC0DE_0000 | 32'(k);
`endif
    end

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_smix_enable", smix_enable, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_smix_data", |smix_data, 1'b0);
    n_rst = 1'b1;
    @(negedge clk);

    // Stray smix_done while loading is ignored
    smix_hash = '1;
    smix_done = 1'b1;
    @(negedge clk);
    smix_done = 1'b0;
    chk("stray_done_in_ready", in_ready, 1'b1);
    chk("stray_done_out_valid", out_valid, 1'b0);
    chk("stray_done_busy", busy, 1'b0);
    chk("stray_done_data", |smix_data, 1'b0);

    // Block A: table vectors, words 0..31, out_ready held high
    for (int k = 0; k < 32; k++) begin
      blk[k] = vecs[k].in_w; hw[k] = vecs[k].hash_w; exp_w[k] = vecs[k].exp_out;
    end
    en0 = en_count;
    load_block(32);
    chk("start_enable", smix_enable, 1'b1);
    for (int k = 0; k < 32; k++)
      chk($sformatf("a_smix_data[%0d]", k), smix_data[k*32 +: 32], vecs[k].exp_data);
    run_smix();
    unload(1'b0, 1'b0);
    chk("a_enable_count", en_count - en0, 1);

    // Block B: constant A5 hash
    for (int k = 0; k < 32; k++) begin
      blk[k] = 32'h100 + 32'(k); hw[k] = 32'hA5A5_A5A5; exp_w[k] = 32'hA5A5_A5A5;
    end
    en0 = en_count;
    load_block(32);
    chk("b_start_enable", smix_enable, 1'b1);
    run_smix();
    unload(1'b0, 1'b0);
    chk("b_enable_count", en_count - en0, 1);

    // Block C: toggled out_ready with stray in_valid and smix_done
    for (int k = 0; k < 32; k++) begin
      blk[k] = 32'(k * 3);
      hw[k] = 32'h5A00_0000 + 32'(k) * 32'h0001_0001;
      exp_w[k] = sw(hw[k]);
    end
    load_block(32);
    run_smix();
    unload(1'b1, 1'b1);

    // Reset in the middle of a load, then reload
    for (int k = 0; k < 32; k++) blk[k] = 32'hFFFF_0000 | 32'(k);
    load_block(10);
    n_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_data", |smix_data, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    n_rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 32; k++) blk[k] = 32'h1000 + 32'(k);
    en0 = en_count;
    load_block(32);
    for (int k = 0; k < 32; k++)
      chk($sformatf("reload_data[%0d]", k), smix_data[k*32 +: 32], sw(32'h1000 + 32'(k)));
    for (int k = 0; k < 32; k++) begin hw[k] = 32'(k); exp_w[k] = sw(32'(k)); end
    run_smix();
    unload(1'b0, 1'b0);
    chk("reload_enable_count", en_count - en0, 1);

`ifdef SCRYPT_IO_BSWAP_EN
    for (int k = 0; k < 32; k++) begin blk[k] = '0; hw[k] = '0; exp_w[k] = '0; end
    blk[0] = 32'h1122_3344;
    hw[0] = 32'hDEAD_BEEF;
    exp_w[0] = 32'hEFBE_ADDE;
    load_block(32);
    chk("bswap_in", smix_data[31:0], 32'h4433_2211);
    run_smix();
    unload(1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
